// File: rtl/muldiv_hilo.sv
// Iterative 32-step multiply / restoring divide feeding architectural HI/LO; signed ops need MULDIV_SIGNED_EN.
// Latency: start edge E0, HI/LO commit and done pulse at E34 for every op and operand.
// Backpressure: busy is held while in flight; start and mthi/mtlo are ignored until commit.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_out_q, dbz_out_d;

  logic               signed_op;
  logic               accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = op[1];
`else
  logic unused_op;
  assign unused_op = op[1];
  assign signed_op = 1'b0;
`endif

  assign a_abs  = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs  = (signed_op && b[WIDTH-1]) ? -b : b;
  // COMMIT is the last busy cycle, so a new launch may overlap it.
  assign accept = start && (state_q == IDLE || state_q == COMMIT);

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opnd_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      DIV: begin
        acc_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (neg_q_q) acc_d[WIDTH-1:0] = -acc_q[WIDTH-1:0];
          if (neg_r_q) acc_d[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
        end else if (neg_q_q) begin
          acc_d = -acc_q;
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        hi_d      = acc_q[2*WIDTH-1:WIDTH];
        lo_d      = acc_q[WIDTH-1:0];
        busy_d    = 1'b0;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      opnd_d   = op[0] ? b_abs : a_abs;
      acc_d    = {{WIDTH{1'b0}}, (op[0] ? a_abs : b_abs)};
      is_div_d = op[0];
      neg_q_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_d  = signed_op && a[WIDTH-1];
      dbz_d    = op[0] && (b == '0);
      cnt_d    = '0;
      busy_d   = 1'b1;
      state_d  = op[0] ? DIV : MUL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails  = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed divide truncates toward zero like SV '/'.
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] ehi, output logic [31:0] elo);
    bit          sgn;
    longint      sa, sb, q, r;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = mop[1];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (!mop[0]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, ma} * {32'b0, mb};
      ehi = p[63:32];
      elo = p[31:0];
    end else if (mb == 32'd0) begin
      elo = 32'hFFFF_FFFF;
      ehi = ma;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      elo = q[31:0];
      ehi = r[31:0];
    end else begin
      elo = ma / mb;
      ehi = ma % mb;
    end
  endfunction

  task automatic launch(input logic [1:0] lop, input logic [31:0] la, input logic [31:0] lb);
    op = lop; a = la; b = lb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done counting edges from the start edge; optionally launch the next op into COMMIT.
  task automatic wait_check(input string tag, input logic [1:0] mop, input logic [31:0] ma,
                            input logic [31:0] mb, input bit chain, input logic [1:0] nop,
                            input logic [31:0] na, input logic [31:0] nb, input int n0);
    int n;
    logic [31:0] ehi, elo;
    model(mop, ma, mb, ehi, elo);
    n = n0;
    while (n < 40) begin
      if (chain && n == 33) begin
        op = nop; a = na; b = nb; start = 1'b1;
      end
      tick();
      n++;
      if (n == 33) chk({tag, ".busy33"}, 32'(busy), 32'd1);
      if (done === 1'b1) break;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(n), 32'd34);
    chk({tag, ".hi"}, hi, ehi);
    chk({tag, ".lo"}, lo, elo);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(mop[0] && mb == 32'd0));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'(chain));
    if (!chain) begin
      tick();
      chk({tag, ".done_fall"}, 32'(done), 32'd0);
      chk({tag, ".dbz_fall"}, 32'(div_by_zero), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  cop, nop;
    logic [31:0] ca, cb, na, nb;
    bit          chain;

    // Reset state
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max.busy_e0", 32'(busy), 32'd1);
    wait_check("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, '0, '0, 0);
    chk("multu_max.hi_lit", hi, 32'hFFFF_FFFE);
    chk("multu_max.lo_lit", lo, 32'h0000_0001);

    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234_5678);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    lo_we = 1'b0;
    chk("mtlo", lo, 32'hCAFE_F00D);

    // start and mthi together: start wins
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("start_vs_mthi.hi", hi, 32'h1234_5678);
    wait_check("start_vs_mthi", 2'b00, 32'd3, 32'd5, 1'b0, 2'b00, '0, '0, 0);

    launch(2'b10, 32'hFFFF_FFFD, 32'd7);
    wait_check("mult_neg3x7", 2'b10, 32'hFFFF_FFFD, 32'd7, 1'b0, 2'b00, '0, '0, 0);
`ifdef MULDIV_SIGNED_EN
    chk("mult_neg3x7.hi_lit", hi, 32'hFFFF_FFFF);
    chk("mult_neg3x7.lo_lit", lo, 32'hFFFF_FFEB);
`endif
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_check("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b00, '0, '0, 0);
`ifdef MULDIV_SIGNED_EN
    chk("div_neg7by2.lo_lit", lo, 32'hFFFF_FFFD);
    chk("div_neg7by2.hi_lit", hi, 32'hFFFF_FFFF);
`endif
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, '0, '0, 0);
`ifdef MULDIV_SIGNED_EN
    chk("div_ovf.lo_lit", lo, 32'h8000_0000);
    chk("div_ovf.hi_lit", hi, 32'h0000_0000);
`endif
    launch(2'b10, 32'hFFFF_FFFF, 32'd2);
    wait_check("mult_m1x2", 2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'b00, '0, '0, 0);
`ifndef MULDIV_SIGNED_EN
    chk("mult_m1x2.hi_lit", hi, 32'h0000_0001);
    chk("mult_m1x2.lo_lit", lo, 32'hFFFF_FFFE);
`endif

    launch(2'b01, 32'd100, 32'd0);
    wait_check("divu_by0", 2'b01, 32'd100, 32'd0, 1'b0, 2'b00, '0, '0, 0);
    chk("divu_by0.lo_lit", lo, 32'hFFFF_FFFF);
    chk("divu_by0.hi_lit", hi, 32'd100);

    // mtlo and a second start while busy are both dropped
    launch(2'b00, 32'h0001_0001, 32'h0003_0003);
    repeat (5) tick();
    lo_we = 1'b1; wdata = 32'h5555_AAAA; start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd4;
    tick();
    lo_we = 1'b0; start = 1'b0;
    wait_check("busy_ignore", 2'b00, 32'h0001_0001, 32'h0003_0003, 1'b0, 2'b00, '0, '0, 6);

    // Back-to-back launch accepted on the commit edge
    launch(2'b01, 32'd1000, 32'd7);
    wait_check("b2b_first", 2'b01, 32'd1000, 32'd7, 1'b1, 2'b00, 32'h0000_ABCD, 32'h0000_1234, 0);
    wait_check("b2b_second", 2'b00, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 2'b00, '0, '0, 0);

    // Randomized ops, sometimes chained
    cop = 2'($urandom_range(0, 3));
    ca  = $urandom;
    cb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    if (cop == 2'b11 && cb == 32'd0) cb = 32'd3;
    launch(cop, ca, cb);
    for (int i = 0; i < 16; i++) begin
      nop = 2'($urandom_range(0, 3));
      na  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      nb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (nop == 2'b11 && nb == 32'd0) nb = 32'd3;
      chain = (i < 15) && ($urandom_range(0, 1) == 1);
      wait_check($sformatf("rand%0d", i), cop, ca, cb, chain, nop, na, nb, 0);
      if (!chain && i < 15) launch(nop, na, nb);
      cop = nop; ca = na; cb = nb;
    end

    // Reset in the middle of a divide
    launch(2'b01, 32'hFFFF_0000, 32'd3);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.hi", hi, 32'd0);
    chk("midrst.lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    launch(2'b00, 32'd6, 32'd7);
    wait_check("post_rst", 2'b00, 32'd6, 32'd7, 1'b0, 2'b00, '0, '0, 0);
    chk("post_rst.lo_lit", lo, 32'd42);
    chk("post_rst.hi_lit", hi, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
